// File: rtl/window_3x3_gen_pkg.sv
// Shared widths and tap count for the 3x3 window generator.
// Imported by the window top and its line buffers.
package window_3x3_gen_pkg;

  localparam int WORD_SIZE = 8;
  localparam int WIN_TAPS  = 9;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One image row of storage, indexed by column.
// Read is combinational so the old value is seen before the write.
import window_3x3_gen_pkg::*;

module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = WORD_SIZE,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 window stream, complete windows only.
// Two line buffers supply the rows above the incoming pixel.
import window_3x3_gen_pkg::*;

module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int XW         = cnt_w(IMG_WIDTH),
  parameter int YW         = cnt_w(IMG_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic [WORD_SIZE-1:0] p1,
  output logic [WORD_SIZE-1:0] p2,
  output logic [WORD_SIZE-1:0] p3,
  output logic [WORD_SIZE-1:0] p4,
  output logic [WORD_SIZE-1:0] p5,
  output logic [WORD_SIZE-1:0] p6,
  output logic [WORD_SIZE-1:0] p7,
  output logic [WORD_SIZE-1:0] p8,
  output logic [WORD_SIZE-1:0] p9,
  output logic                 out_valid,
  output logic [XW-1:0]        out_x,
  output logic [YW-1:0]        out_y
);

  localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x, ex, nx;
  logic [YW-1:0] y, ey, ny;
  logic [WORD_SIZE-1:0] rd1, rd2;
  logic [WORD_SIZE-1:0] win [WIN_TAPS];
  logic full;

  // in_sof overrides the counters for this pixel itself
  always_comb begin
    ex = in_sof ? '0 : x;
    ey = in_sof ? '0 : y;
    nx = ex + 1'b1;
    ny = ey;
    if (ex == XMAX) begin
      nx = '0;
      ny = (ey == YMAX) ? '0 : ey + 1'b1;
    end
    full = (ex >= XW'(2)) && (ey >= YW'(2));
  end

  line_buffer #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(WORD_SIZE),
    .AW   (XW)
  ) u_lb1 (
    .clk  (clk),
    .we   (in_valid),
    .addr (ex),
    .wdata(in_pixel),
    .rdata(rd1)
  );

  line_buffer #(
    .DEPTH(IMG_WIDTH),
    .WIDTH(WORD_SIZE),
    .AW   (XW)
  ) u_lb2 (
    .clk  (clk),
    .we   (in_valid),
    .addr (ex),
    .wdata(rd1),
    .rdata(rd2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      for (int i = 0; i < WIN_TAPS; i++) win[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        x         <= nx;
        y         <= ny;
        out_valid <= full;
        out_x     <= ex - 1'b1;
        out_y     <= ey - 1'b1;
        win[0]    <= win[1];
        win[1]    <= win[2];
        win[2]    <= rd2;
        win[3]    <= win[4];
        win[4]    <= win[5];
        win[5]    <= rd1;
        win[6]    <= win[7];
        win[7]    <= win[8];
        win[8]    <= in_pixel;
      end
    end
  end

  assign p1 = win[0];
  assign p2 = win[1];
  assign p3 = win[2];
  assign p4 = win[3];
  assign p5 = win[4];
  assign p6 = win[5];
  assign p7 = win[6];
  assign p8 = win[7];
  assign p9 = win[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 5x4 image.
// Reference keeps the frame as a 2D array and cuts windows from it.
import window_3x3_gen_pkg::*;

module tb_window_3x3_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic clk = 0;
  logic reset = 0;
  logic in_valid = 0;
  logic in_sof = 0;
  logic [WORD_SIZE-1:0] in_pixel = '0;
  logic [WORD_SIZE-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic out_valid;
  logic [2:0] out_x;
  logic [1:0] out_y;

  window_3x3_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_pixel (in_pixel),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .p4       (p4),
    .p5       (p5),
    .p6       (p6),
    .p7       (p7),
    .p8       (p8),
    .p9       (p9),
    .out_valid(out_valid),
    .out_x    (out_x),
    .out_y    (out_y)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  int img [H][W];
  int mx, my;
  int hist [3];
  int ew [9];
  bit win_known;
  int pulses;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic int tap(input int i);
    case (i)
      0: return int'(p1);
      1: return int'(p2);
      2: return int'(p3);
      3: return int'(p4);
      4: return int'(p5);
      5: return int'(p6);
      6: return int'(p7);
      7: return int'(p8);
      default: return int'(p9);
    endcase
  endfunction

  task automatic model_reset();
    mx = 0;
    my = 0;
    hist = '{0, 0, 0};
    ew = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    win_known = 1;
  endtask

  task automatic check_rows();
    check("p7", int'(p7), hist[0]);
    check("p8", int'(p8), hist[1]);
    check("p9", int'(p9), hist[2]);
    if (win_known)
      for (int i = 0; i < 9; i++) check($sformatf("tap%0d", i + 1), tap(i), ew[i]);
  endtask

  task automatic push(input int pix, input bit sof);
    int ex, ey;
    bit v;
    @(negedge clk);
    in_valid = 1;
    in_sof = sof;
    in_pixel = WORD_SIZE'(pix);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_sof = 0;
    ex = sof ? 0 : mx;
    ey = sof ? 0 : my;
    img[ey][ex] = pix & 8'hff;
    hist[0] = hist[1];
    hist[1] = hist[2];
    hist[2] = pix & 8'hff;
    v = (ex >= 2) && (ey >= 2);
    check("out_valid", int'(out_valid), int'(v));
    win_known = v;
    if (v) begin
      pulses++;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          ew[r*3+c] = img[ey-2+r][ex-2+c];
      check("out_x", int'(out_x), ex - 1);
      check("out_y", int'(out_y), ey - 1);
    end
    check_rows();
    mx = ex + 1;
    my = ey;
    if (mx == W) begin
      mx = 0;
      my = (ey == H - 1) ? 0 : ey + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0;
      @(posedge clk);
      #1;
      check("idle_valid", int'(out_valid), 0);
      check_rows();
    end
  endtask

  task automatic frame(input int base, input bit sof, input int stall_after);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        push(base + 10*y + x, sof && x == 0 && y == 0);
        if (10*y + x == stall_after) idle(3);
      end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_x"}, int'(out_x), 0);
    check({tag, "_y"}, int'(out_y), 0);
    for (int i = 0; i < 9; i++) check($sformatf("%s_tap%0d", tag, i + 1), tap(i), 0);
  endtask

  initial begin
    reset = 1;
    #12;
    check_zero("rst");
    @(negedge clk);
    reset = 0;
    model_reset();
    idle(1);

    // full frame, includes the row wrap 30,31,32
    pulses = 0;
    frame(0, 1, -1);
    check("frame1_pulses", pulses, 6);

    // stall between 23 and 24
    pulses = 0;
    frame(0, 1, 23);
    check("stall_pulses", pulses, 6);

    // back-to-back frame without in_sof
    pulses = 0;
    frame(100, 0, -1);
    check("b2b_pulses", pulses, 6);

    // abandon a frame at (3,2) with in_sof
    for (int i = 0; i < 13; i++) push(50 + i, i == 0);
    pulses = 0;
    frame(0, 1, -1);
    check("sof_mid_pulses", pulses, 6);

    // async reset in row 2, then restream without in_sof
    for (int i = 0; i < 12; i++) push(10*(i/W) + i%W, i == 0);
    #2;
    reset = 1;
    #1;
    check_zero("arst");
    @(negedge clk);
    reset = 0;
    model_reset();
    pulses = 0;
    frame(0, 0, -1);
    check("arst_pulses", pulses, 6);

    // random traffic with occasional stalls and restarts
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else push(int'($urandom_range(255)), $urandom_range(40) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
